path_backtrace: RTL and testbench

- Downstream of the explored-set RAM and its parent-lookup stage.
- After the search reaches the goal, this block walks the parent chain from goal_id back to the start node by scanning the explored RAM.
- Each visited node is pushed onto an internal LIFO.
- The path is then streamed out start-first over a valid/ready interface to the route output logic.

---
 rtl/pathfinding_pkg.sv | 49 ++++
 rtl/path_lifo.sv | 60 ++++++
 rtl/path_backtrace.sv | 202 ++++++++++++++++++++
 tb/tb_path_backtrace.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pathfinding_pkg.sv
// rtl/pathfinding_pkg.sv - shared pathfinding types, widths and error codes
package pathfinding_pkg;

    localparam int          NODE_INFO_W  = 272;
    localparam logic [15:0] NODE_ID_NULL = 16'd0;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_NOT_FOUND = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_GOAL_ZERO = 2'b11;

    // Compact node as carried along the path (48 bits).
    typedef struct packed {
        logic [15:0] node_id;
        logic [15:0] x;
        logic [15:0] y;
    } map_node;

    // Full explored-set entry as stored in the explored RAM (272 bits).
    typedef struct packed {
        logic [15:0]  node_id;
        logic [15:0]  parent_node_id;
        logic [15:0]  x;
        logic [15:0]  y;
        logic [31:0]  g_cost;
        logic [31:0]  f_cost;
        logic [143:0] rsvd;
    } node_info;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_SET,
        ST_SCAN_WAIT,
        ST_SCAN_CHECK,
        ST_PUSH,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } bt_state_e;

    function automatic map_node to_map_node(input node_info n);
        map_node m;
        m.node_id = n.node_id;
        m.x       = n.x;
        m.y       = n.y;
        return m;
    endfunction

endpackage

// File: rtl/path_lifo.sv
// rtl/path_lifo.sv - register stack of path nodes with registered top of stack
module path_lifo
    import pathfinding_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  map_node                    din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output map_node                    top
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    map_node       mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    map_node       top_q;
    logic [DW-1:0] below_d;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    // Entry just below the current top becomes the new top after a pop.
    assign below_d = depth_q - DW'(2);
    assign wr_idx  = depth_q[IW-1:0];
    assign rd_idx  = below_d[IW-1:0];

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;
    assign top   = top_q;

    // Storage array; contents are don't-care above depth so no reset needed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

    // Depth counter and registered top; push wins over pop if both requested.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            depth_q <= '0;
            top_q   <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + DW'(1);
            top_q   <= din;
        end else if (pop && !empty) begin
            depth_q <= depth_q - DW'(1);
            top_q   <= (depth_q > DW'(1)) ? mem_q[rd_idx] : '0;
        end
    end

endmodule

// File: rtl/path_backtrace.sv
// rtl/path_backtrace.sv - walk parent chain from goal to start and stream path start-first
module path_backtrace
    import pathfinding_pkg::*;
#(
    parameter int MAX_NODES = 100,
    parameter int MAX_PATH  = 64,
    parameter int ADDR_W    = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            goal_id,
    output logic [ADDR_W-1:0]      ram_rd_addr,
    input  logic [NODE_INFO_W-1:0] ram_rd_node,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_node_id,
    output logic [15:0]            out_x,
    output logic [15:0]            out_y,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code,
    output logic [ADDR_W-1:0]      path_len
);

    localparam int LIFO_DW = $clog2(MAX_PATH + 1);

    node_info          rd_info;
    logic              unused_rd_fields;

    bt_state_e         state_q;
    logic [15:0]       target_q;
    logic [ADDR_W-1:0] addr_q;
    map_node           node_q;
    logic [15:0]       parent_q;
    logic              out_valid_q;
    logic [15:0]       out_node_id_q;
    logic [15:0]       out_x_q;
    logic [15:0]       out_y_q;
    logic              out_last_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [1:0]        error_code_q;
    logic [ADDR_W-1:0] path_len_q;

    logic               lifo_push;
    logic               lifo_pop;
    logic               lifo_clear;
    logic               lifo_full;
    logic               lifo_empty;
    logic [LIFO_DW-1:0] lifo_depth;
    map_node            lifo_top;

    assign rd_info          = ram_rd_node;
    assign unused_rd_fields = ^{rd_info.g_cost, rd_info.f_cost, rd_info.rsvd};

    // Stack is fed from the node captured in SCAN_CHECK and drained by accepted beats.
    assign lifo_push  = (state_q == ST_PUSH) && !lifo_full;
    assign lifo_pop   = (state_q == ST_EMIT) && out_valid_q && out_ready;
    assign lifo_clear = (state_q == ST_ERR);

    path_lifo #(
        .DEPTH (MAX_PATH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .clear (lifo_clear),
        .push  (lifo_push),
        .din   (node_q),
        .pop   (lifo_pop),
        .full  (lifo_full),
        .empty (lifo_empty),
        .depth (lifo_depth),
        .top   (lifo_top)
    );

    // Backtrace controller: scan RAM for target, push, follow parent, then emit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            addr_q        <= '0;
            node_q        <= '0;
            parent_q      <= '0;
            out_valid_q   <= 1'b0;
            out_node_id_q <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            error_code_q  <= ERR_NONE;
            path_len_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (goal_id == NODE_ID_NULL) begin
                            error_q      <= 1'b1;
                            error_code_q <= ERR_GOAL_ZERO;
                            state_q      <= ST_ERR;
                        end else begin
                            target_q     <= goal_id;
                            addr_q       <= '0;
                            error_q      <= 1'b0;
                            error_code_q <= ERR_NONE;
                            path_len_q   <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_SCAN_WAIT;
                        end
                    end
                end
                ST_SCAN_SET: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    state_q <= ST_SCAN_WAIT;
                end
                ST_SCAN_WAIT: begin
                    state_q <= ST_SCAN_CHECK;
                end
                ST_SCAN_CHECK: begin
                    if (rd_info.node_id == target_q) begin
                        node_q   <= to_map_node(rd_info);
                        parent_q <= rd_info.parent_node_id;
                        state_q  <= ST_PUSH;
                    end else if ((rd_info.node_id == NODE_ID_NULL) ||
                                 (addr_q == ADDR_W'(MAX_NODES - 1))) begin
                        error_q      <= 1'b1;
                        error_code_q <= ERR_NOT_FOUND;
                        busy_q       <= 1'b0;
                        state_q      <= ST_ERR;
                    end else begin
                        state_q <= ST_SCAN_SET;
                    end
                end
                ST_PUSH: begin
                    if (lifo_full) begin
                        error_q      <= 1'b1;
                        error_code_q <= ERR_OVERFLOW;
                        busy_q       <= 1'b0;
                        state_q      <= ST_ERR;
                    end else begin
                        path_len_q <= path_len_q + ADDR_W'(1);
                        if (parent_q == NODE_ID_NULL) begin
                            state_q <= ST_EMIT;
                        end else begin
                            target_q <= parent_q;
                            addr_q   <= '0;
                            state_q  <= ST_SCAN_WAIT;
                        end
                    end
                end
                ST_EMIT: begin
                    // Load a beat from the registered top, hold it until accepted.
                    if (!out_valid_q) begin
                        if (!lifo_empty) begin
                            out_node_id_q <= lifo_top.node_id;
                            out_x_q       <= lifo_top.x;
                            out_y_q       <= lifo_top.y;
                            out_last_q    <= (lifo_depth == LIFO_DW'(1));
                            out_valid_q   <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            out_last_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_rd_addr = addr_q;
    assign out_valid   = out_valid_q;
    assign out_node_id = out_node_id_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign error_code  = error_code_q;
    assign path_len    = path_len_q;

endmodule

// File: tb/tb_path_backtrace.sv
// tb/tb_path_backtrace.sv - directed self-checking bench for path_backtrace
module tb_path_backtrace;
    import pathfinding_pkg::*;

    localparam int ADDR_W    = 7;
    localparam int MAX_NODES = 100;
    localparam int MAX_PATH  = 8;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [15:0]            goal_id;
    logic [ADDR_W-1:0]      ram_rd_addr;
    logic [NODE_INFO_W-1:0] ram_rd_node;
    logic                   out_valid;
    logic                   out_ready;
    logic [15:0]            out_node_id;
    logic [15:0]            out_x;
    logic [15:0]            out_y;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [1:0]             error_code;
    logic [ADDR_W-1:0]      path_len;

    path_backtrace #(
        .MAX_NODES (MAX_NODES),
        .MAX_PATH  (MAX_PATH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .goal_id     (goal_id),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_node (ram_rd_node),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_node_id (out_node_id),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .error_code  (error_code),
        .path_len    (path_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Explored RAM model: address registered in the DUT, data registered here,
    // so the word seen in SCAN_CHECK belongs to the address set before SCAN_WAIT.
    node_info ram [128];
    always_ff @(posedge clk) ram_rd_node <= ram[ram_rd_addr];

    int total = 0;
    int bad   = 0;
    int got_id[$];
    int got_x[$];
    int got_y[$];
    int got_last[$];
    int valid_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    function automatic node_info mk(input int id, input int parent);
        node_info n;
        n = '0;
        n.node_id        = 16'(id);
        n.parent_node_id = 16'(parent);
        n.x              = 16'(id * 10);
        n.y              = 16'(id * 10 + 1);
        n.g_cost         = 32'(id + 1000);
        return n;
    endfunction

    task automatic clear_ram();
        for (int i = 0; i < 128; i++) ram[i] = '0;
    endtask

    task automatic load_chain();
        clear_ram();
        ram[0] = mk(5, 0);
        ram[1] = mk(9, 5);
        ram[2] = mk(12, 9);
    endtask

    task automatic go(input logic [15:0] g);
        @(negedge clk);
        start   = 1'b1;
        goal_id = g;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Accept the stream; the first beat is held off for 'stall' cycles.
    task automatic collect(input int stall, input int budget);
        int      stalled;
        logic    fin;
        map_node snap;
        logic    snap_last;
        stalled = 0;
        fin     = 1'b0;
        snap    = '0;
        snap_last = 1'b0;
        got_id.delete(); got_x.delete(); got_y.delete(); got_last.delete();
        out_ready = (stall == 0);
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            if (done) fin = 1'b1;
            if (out_valid) begin
                if (stalled <= stall) begin
                    if (stalled == 0) begin
                        snap.node_id = out_node_id;
                        snap.x       = out_x;
                        snap.y       = out_y;
                        snap_last    = out_last;
                    end else begin
                        chk("hold_id", 32'(out_node_id), 32'(snap.node_id));
                        chk("hold_x", 32'(out_x), 32'(snap.x));
                        chk("hold_y", 32'(out_y), 32'(snap.y));
                        chk("hold_last", 32'(out_last), 32'(snap_last));
                    end
                    stalled++;
                    out_ready = (stalled > stall);
                end
                if (out_ready) begin
                    got_id.push_back(int'(out_node_id));
                    got_x.push_back(int'(out_x));
                    got_y.push_back(int'(out_y));
                    got_last.push_back(int'(out_last));
                end
            end
        end
        chk("done_pulse", 32'(fin), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_path(input string tag);
        int exp_id[3];
        exp_id[0] = 5;
        exp_id[1] = 9;
        exp_id[2] = 12;
        chk({tag, "_count"}, 32'(got_id.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_id.size(); i++) begin
            chk({tag, "_id"}, 32'(got_id[i]), 32'(exp_id[i]));
            chk({tag, "_x"}, 32'(got_x[i]), 32'(exp_id[i] * 10));
            chk({tag, "_y"}, 32'(got_y[i]), 32'(exp_id[i] * 10 + 1));
            chk({tag, "_last"}, 32'(got_last[i]), (i == 2) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wait_error(input int budget);
        logic seen;
        seen      = 1'b0;
        valid_cnt = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (out_valid) valid_cnt++;
            if (error) seen = 1'b1;
        end
        chk("error_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        goal_id   = '0;
        out_ready = 1'b0;
        clear_ram();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_code", 32'(error_code), 32'd0);
        chk("rst_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_len", 32'(path_len), 32'd0);
        reset = 1'b0;

        // goal_id zero
        go(16'd0);
        chk("g0_error", 32'(error), 32'd1);
        chk("g0_code", 32'(error_code), 32'd3);
        chk("g0_busy", 32'(busy), 32'd0);
        chk("g0_addr", 32'(ram_rd_addr), 32'd0);
        @(negedge clk);
        chk("g0_sticky", 32'(error), 32'd1);
        chk("g0_addr2", 32'(ram_rd_addr), 32'd0);

        // main path 5 -> 9 -> 12
        load_chain();
        go(16'd12);
        chk("main_busy", 32'(busy), 32'd1);
        chk("main_err_clr", 32'(error), 32'd0);
        collect(0, 400);
        check_path("main");
        chk("main_len", 32'(path_len), 32'd3);
        chk("main_error", 32'(error), 32'd0);

        // goal not present, list terminated at entry 3
        go(16'd7);
        wait_error(400);
        chk("nf_code", 32'(error_code), 32'd1);
        chk("nf_busy", 32'(busy), 32'd0);
        chk("nf_novalid", 32'(valid_cnt), 32'd0);
        chk("nf_addr", 32'(ram_rd_addr), 32'd3);

        // parent loop 4 <-> 6
        clear_ram();
        ram[0] = mk(4, 6);
        ram[1] = mk(6, 4);
        go(16'd4);
        wait_error(1000);
        chk("loop_code", 32'(error_code), 32'd2);
        chk("loop_len", 32'(path_len), 32'd8);
        chk("loop_busy", 32'(busy), 32'd0);
        chk("loop_novalid", 32'(valid_cnt), 32'd0);

        // single-node path
        clear_ram();
        ram[0] = mk(9, 0);
        ram[1] = mk(5, 0);
        go(16'd5);
        collect(0, 400);
        chk("one_count", 32'(got_id.size()), 32'd1);
        if (got_id.size() > 0) begin
            chk("one_id", 32'(got_id[0]), 32'd5);
            chk("one_last", 32'(got_last[0]), 32'd1);
        end
        chk("one_len", 32'(path_len), 32'd1);

        // backpressure on the first beat
        load_chain();
        go(16'd12);
        collect(5, 400);
        check_path("bp");
        chk("bp_len", 32'(path_len), 32'd3);

        // reset while scanning for the second node, then a clean rerun
        go(16'd12);
        begin
            logic pushed;
            pushed = 1'b0;
            for (int c = 0; c < 200 && !pushed; c++) begin
                @(negedge clk);
                if (path_len == ADDR_W'(1)) pushed = 1'b1;
            end
            chk("mid_first_push", 32'(pushed), 32'd1);
        end
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_busy0", 32'(busy), 32'd0);
        chk("mid_addr", 32'(ram_rd_addr), 32'd0);
        chk("mid_len", 32'(path_len), 32'd0);
        chk("mid_error", 32'(error), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_id", 32'(out_node_id), 32'd0);
        go(16'd12);
        collect(0, 400);
        check_path("rerun");
        chk("rerun_len", 32'(path_len), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
